// File: rtl/enqueue_agent.sv
`timescale 1ns / 1ps
// enqueue_agent
// Ingress front-end of the PIFO scheduler. The accept/drop decision is made once per
// packet, on its first beat, from the destination mask and the buffer/PIFO almost-full
// status. The design then forwards the beat, metadata and descriptors with a one-cycle
// registered latency, together with write/enqueue strobes for the downstream stores.
//
// Ports
//   clk, rstn                            clock; asynchronous reset, active-high despite its name
//   s_axis_pkt_data/keep/last            incoming packet beat
//   s_axis_sume_meta                     {pifo0..pifo4, meta}; pifo0 occupies the MSBs
//   s_axis_valid                         beat valid (valid=0 is a stall)
//   s_axis_buffer_almost_full_bit_array  per-queue packet buffer almost full
//   s_axis_pifo_almost_full_bit_array    per-PIFO almost full
//   m_axis_pkt_info                      {data, keep, last} of the last valid beat
//   m_axis_sume_meta, m_axis_pifo_info   latched on every accepted SOP
//   m_axis_output_port_bit_array         destination mask, latched on every accepted SOP
//   m_axis_ctl_*                         one-cycle strobes for accepted beats and packets
module enqueue_agent #(
    parameter int unsigned DATA_W         = 256,
    parameter int unsigned KEEP_W         = 32,
    parameter int unsigned META_W         = 128,
    parameter int unsigned PIFO_W         = 37,
    parameter int unsigned NUM_Q          = 5,   // port mask decode below assumes 5 queues
    parameter int unsigned DST_POS        = 24,
    parameter int unsigned PIFO_VALID_POS = 36
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DATA_W-1:0]               s_axis_pkt_data,
    input  logic [KEEP_W-1:0]               s_axis_pkt_keep,
    input  logic                            s_axis_pkt_last,
    input  logic [NUM_Q*PIFO_W+META_W-1:0]  s_axis_sume_meta,
    input  logic                            s_axis_valid,
    input  logic [NUM_Q-1:0]                s_axis_buffer_almost_full_bit_array,
    input  logic [NUM_Q-1:0]                s_axis_pifo_almost_full_bit_array,
    output logic [DATA_W+KEEP_W:0]          m_axis_pkt_info,
    output logic [META_W-1:0]               m_axis_sume_meta,
    output logic [NUM_Q*PIFO_W-1:0]         m_axis_pifo_info,
    output logic [NUM_Q-1:0]                m_axis_output_port_bit_array,
    output logic                            m_axis_ctl_pkt_wr_en,
    output logic                            m_axis_ctl_meta_wr_en,
    output logic                            m_axis_ctl_pifo_enq,
    output logic                            m_axis_ctl_pkt_addr_update,
    output logic                            m_axis_ctl_meta_addr_update
);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StDrop
    } state_e;

    state_e state;

    logic [META_W-1:0]       meta_in;
    logic [NUM_Q*PIFO_W-1:0] pifo_in;
    logic [7:0]              dst;
    logic [NUM_Q-1:0]        port;
    logic [NUM_Q-1:0]        pifo_valid;
    logic                    drop;

    assign meta_in = s_axis_sume_meta[META_W-1:0];
    assign pifo_in = s_axis_sume_meta[NUM_Q*PIFO_W+META_W-1:META_W];
    assign dst     = meta_in[DST_POS+7:DST_POS];

    // Even dst bits map to queues 0..3; all odd bits fold onto queue 4.
    assign port[0] = dst[0];
    assign port[1] = dst[2];
    assign port[2] = dst[4];
    assign port[3] = dst[6];
    assign port[4] = dst[1] | dst[3] | dst[5] | dst[7];

    // Descriptor k sits at slot (NUM_Q-1-k) so that pifo0 lands in the MSBs.
    for (genvar k = 0; k < NUM_Q; k++) begin : g_pifo_valid
        assign pifo_valid[k] = pifo_in[PIFO_W*(NUM_Q-1-k) + PIFO_VALID_POS];
    end

    assign drop = (|(port & s_axis_buffer_almost_full_bit_array))
                | (|(pifo_valid & s_axis_pifo_almost_full_bit_array))
                | (port == '0);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state                        <= StIdle;
            m_axis_pkt_info              <= '0;
            m_axis_sume_meta             <= '0;
            m_axis_pifo_info             <= '0;
            m_axis_output_port_bit_array <= '0;
            m_axis_ctl_pkt_wr_en         <= 1'b0;
            m_axis_ctl_meta_wr_en        <= 1'b0;
            m_axis_ctl_pifo_enq          <= 1'b0;
            m_axis_ctl_pkt_addr_update   <= 1'b0;
            m_axis_ctl_meta_addr_update  <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            m_axis_ctl_pkt_wr_en        <= 1'b0;
            m_axis_ctl_meta_wr_en       <= 1'b0;
            m_axis_ctl_pifo_enq         <= 1'b0;
            m_axis_ctl_pkt_addr_update  <= 1'b0;
            m_axis_ctl_meta_addr_update <= 1'b0;

            if (s_axis_valid) begin
                m_axis_pkt_info <= {s_axis_pkt_data, s_axis_pkt_keep, s_axis_pkt_last};
            end

            unique case (state)
                StIdle: begin
                    if (s_axis_valid) begin
                        if (drop) begin
                            state <= s_axis_pkt_last ? StIdle : StDrop;
                        end else begin
                            m_axis_sume_meta             <= meta_in;
                            m_axis_pifo_info             <= pifo_in;
                            m_axis_output_port_bit_array <= port;
                            m_axis_ctl_pkt_wr_en         <= 1'b1;
                            m_axis_ctl_pkt_addr_update   <= 1'b1;
                            if (s_axis_pkt_last) begin
                                m_axis_ctl_meta_wr_en       <= 1'b1;
                                m_axis_ctl_meta_addr_update <= 1'b1;
                                m_axis_ctl_pifo_enq         <= 1'b1;
                                state                       <= StIdle;
                            end else begin
                                state <= StAccept;
                            end
                        end
                    end
                end
                StAccept: begin
                    if (s_axis_valid) begin
                        m_axis_ctl_pkt_wr_en       <= 1'b1;
                        m_axis_ctl_pkt_addr_update <= 1'b1;
                        if (s_axis_pkt_last) begin
                            m_axis_ctl_meta_wr_en       <= 1'b1;
                            m_axis_ctl_meta_addr_update <= 1'b1;
                            m_axis_ctl_pifo_enq         <= 1'b1;
                            state                       <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (s_axis_valid && s_axis_pkt_last) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enqueue_agent.sv
`timescale 1ns / 1ps
module tb_enqueue_agent;

    logic         clk;
    logic         rstn;
    logic [255:0] s_axis_pkt_data;
    logic [31:0]  s_axis_pkt_keep;
    logic         s_axis_pkt_last;
    logic [312:0] s_axis_sume_meta;
    logic         s_axis_valid;
    logic [4:0]   s_axis_buffer_almost_full_bit_array;
    logic [4:0]   s_axis_pifo_almost_full_bit_array;
    logic [288:0] m_axis_pkt_info;
    logic [127:0] m_axis_sume_meta;
    logic [184:0] m_axis_pifo_info;
    logic [4:0]   m_axis_output_port_bit_array;
    logic         m_axis_ctl_pkt_wr_en;
    logic         m_axis_ctl_meta_wr_en;
    logic         m_axis_ctl_pifo_enq;
    logic         m_axis_ctl_pkt_addr_update;
    logic         m_axis_ctl_meta_addr_update;

    int n_cmp;
    int n_err;

    enqueue_agent dut (
        .clk                                 (clk),
        .rstn                                (rstn),
        .s_axis_pkt_data                     (s_axis_pkt_data),
        .s_axis_pkt_keep                     (s_axis_pkt_keep),
        .s_axis_pkt_last                     (s_axis_pkt_last),
        .s_axis_sume_meta                    (s_axis_sume_meta),
        .s_axis_valid                        (s_axis_valid),
        .s_axis_buffer_almost_full_bit_array (s_axis_buffer_almost_full_bit_array),
        .s_axis_pifo_almost_full_bit_array   (s_axis_pifo_almost_full_bit_array),
        .m_axis_pkt_info                     (m_axis_pkt_info),
        .m_axis_sume_meta                    (m_axis_sume_meta),
        .m_axis_pifo_info                    (m_axis_pifo_info),
        .m_axis_output_port_bit_array        (m_axis_output_port_bit_array),
        .m_axis_ctl_pkt_wr_en                (m_axis_ctl_pkt_wr_en),
        .m_axis_ctl_meta_wr_en               (m_axis_ctl_meta_wr_en),
        .m_axis_ctl_pifo_enq                 (m_axis_ctl_pifo_enq),
        .m_axis_ctl_pkt_addr_update          (m_axis_ctl_pkt_addr_update),
        .m_axis_ctl_meta_addr_update         (m_axis_ctl_meta_addr_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order: {pkt_wr_en, pkt_addr_update, meta_wr_en, meta_addr_update, pifo_enq}
    logic [4:0]   strb;
    logic [639:0] all_out;
    assign strb = {m_axis_ctl_pkt_wr_en, m_axis_ctl_pkt_addr_update, m_axis_ctl_meta_wr_en,
                   m_axis_ctl_meta_addr_update, m_axis_ctl_pifo_enq};
    assign all_out = {28'h0, m_axis_pkt_info, m_axis_sume_meta, m_axis_pifo_info,
                      m_axis_output_port_bit_array, strb};

    localparam logic [4:0] StrbNone = 5'b00000;
    localparam logic [4:0] StrbBeat = 5'b11000;
    localparam logic [4:0] StrbLast = 5'b11111;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_meta(input logic [7:0] dst, input logic [31:0] tag);
        return {64'h0123_4567_89AB_CDEF, tag, dst, 24'hC0FFEE};
    endfunction

    function automatic logic [312:0] mk_sume(input logic [127:0] m, input logic [4:0] pv);
        logic [312:0] s;
        s[127:0] = m;
        for (int k = 0; k < 5; k++) begin
            s[128 + 37*(4-k) +: 37] = {pv[k], 32'hA5A5_0000, 4'(k)};
        end
        return s;
    endfunction

    // Drives one valid beat at the falling edge; returns 1ns after the sampling edge.
    task automatic send_beat(input logic [255:0] data, input logic last,
                             input logic [312:0] sume, input logic [4:0] baf,
                             input logic [4:0] paf);
        @(negedge clk);
        s_axis_pkt_data                     = data;
        s_axis_pkt_keep                     = 32'hFFFF_FFFF;
        s_axis_pkt_last                     = last;
        s_axis_sume_meta                    = sume;
        s_axis_buffer_almost_full_bit_array = baf;
        s_axis_pifo_almost_full_bit_array   = paf;
        s_axis_valid                        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stall_cycle();
        @(negedge clk);
        s_axis_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] m_a, m_b, m_c, m_d;
    logic [312:0] sume_a, sume_b, sume_c, sume_d, sume_x;
    logic [255:0] d1, d2, d3;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b1;
        s_axis_pkt_data = '0;
        s_axis_pkt_keep = '0;
        s_axis_pkt_last = 1'b0;
        s_axis_sume_meta = '0;
        s_axis_valid = 1'b0;
        s_axis_buffer_almost_full_bit_array = '0;
        s_axis_pifo_almost_full_bit_array   = '0;

        d1 = 256'h123123123123123123;
        d2 = 256'h2222222222222222;
        d3 = 256'h33333333333333333333333333;

        // Reset
        repeat (20) @(posedge clk);
        #1;
        check("reset_outputs", all_out, '0);
        @(negedge clk);
        rstn = 1'b0;
        stall_cycle();
        stall_cycle();
        check("post_release_idle", all_out, '0);

        // Buffer almost-full drop: dst=0x01 -> queue 0, queue 0 buffer almost full
        m_a    = mk_meta(8'h01, 32'hAAAA_0001);
        sume_a = mk_sume(m_a, 5'b11111);
        send_beat(d1, 1'b0, sume_a, 5'b00001, 5'b00100);
        check("bufdrop_b1_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("bufdrop_b1_info", {351'h0, m_axis_pkt_info}, {351'h0, d1, 32'hFFFF_FFFF, 1'b0});
        check("bufdrop_port", {635'h0, m_axis_output_port_bit_array}, '0);
        send_beat(d2, 1'b1, sume_a, 5'b00001, 5'b00100);
        check("bufdrop_b2_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("bufdrop_meta", {512'h0, m_axis_sume_meta}, '0);

        // Normal accept: 3 beats, pifo0/1 valid, pifo2 almost full but invalid
        m_b    = mk_meta(8'h01, 32'hBBBB_0002);
        sume_b = mk_sume(m_b, 5'b00011);
        send_beat(d1, 1'b0, sume_b, 5'b00000, 5'b00100);
        check("acc_b1_strb", {635'h0, strb}, {635'h0, StrbBeat});
        check("acc_port", {635'h0, m_axis_output_port_bit_array}, {635'h0, 5'b00001});
        check("acc_meta", {512'h0, m_axis_sume_meta}, {512'h0, m_b});
        check("acc_pifo", {455'h0, m_axis_pifo_info}, {455'h0, sume_b[312:128]});
        send_beat(d2, 1'b0, sume_b, 5'b00000, 5'b00100);
        check("acc_b2_strb", {635'h0, strb}, {635'h0, StrbBeat});
        check("acc_b2_info", {351'h0, m_axis_pkt_info}, {351'h0, d2, 32'hFFFF_FFFF, 1'b0});
        send_beat(d3, 1'b1, sume_b, 5'b00000, 5'b00100);
        check("acc_b3_strb", {635'h0, strb}, {635'h0, StrbLast});
        check("acc_b3_info", {351'h0, m_axis_pkt_info}, {351'h0, d3, 32'hFFFF_FFFF, 1'b1});
        stall_cycle();
        check("acc_after_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("acc_after_info_hold", {351'h0, m_axis_pkt_info},
              {351'h0, d3, 32'hFFFF_FFFF, 1'b1});

        // PIFO almost-full drop: pifo0 valid and full
        m_c    = mk_meta(8'h01, 32'hCCCC_0003);
        sume_c = mk_sume(m_c, 5'b00011);
        send_beat(d1, 1'b0, sume_c, 5'b00000, 5'b00001);
        check("pdrop_b1_strb", {635'h0, strb}, {635'h0, StrbNone});
        send_beat(d2, 1'b0, sume_c, 5'b00000, 5'b00000);
        check("pdrop_b2_strb", {635'h0, strb}, {635'h0, StrbNone});
        send_beat(d3, 1'b1, sume_c, 5'b00000, 5'b00000);
        check("pdrop_b3_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("pdrop_meta_held", {512'h0, m_axis_sume_meta}, {512'h0, m_b});

        // Single-beat packet, dst=0x04 -> queue 1
        m_d    = mk_meta(8'h04, 32'hDDDD_0004);
        sume_d = mk_sume(m_d, 5'b00001);
        send_beat(d2, 1'b1, sume_d, 5'b00000, 5'b00000);
        check("single_strb", {635'h0, strb}, {635'h0, StrbLast});
        check("single_port", {635'h0, m_axis_output_port_bit_array}, {635'h0, 5'b00010});

        // Two beats with a 2-cycle gap, dst=0x02 -> queue 4 (odd bit)
        m_a    = mk_meta(8'h02, 32'hEEEE_0005);
        sume_a = mk_sume(m_a, 5'b00001);
        sume_x = mk_sume(mk_meta(8'h00, 32'hFFFF_FFFF), 5'b11111);
        send_beat(d1, 1'b0, sume_a, 5'b00010, 5'b00000);
        check("gap_b1_strb", {635'h0, strb}, {635'h0, StrbBeat});
        check("gap_port", {635'h0, m_axis_output_port_bit_array}, {635'h0, 5'b10000});
        @(negedge clk);
        s_axis_sume_meta = sume_x;
        s_axis_buffer_almost_full_bit_array = 5'b11111;
        stall_cycle();
        check("gap_s1_strb", {635'h0, strb}, {635'h0, StrbNone});
        stall_cycle();
        check("gap_s2_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("gap_meta_held", {512'h0, m_axis_sume_meta}, {512'h0, m_a});
        // Later beat carries junk metadata and full flags; both must be ignored.
        send_beat(d3, 1'b1, sume_x, 5'b11111, 5'b11111);
        check("gap_b2_strb", {635'h0, strb}, {635'h0, StrbLast});
        check("gap_b2_meta", {512'h0, m_axis_sume_meta}, {512'h0, m_a});

        // Empty destination mask -> drop
        send_beat(d1, 1'b1, mk_sume(mk_meta(8'h00, 32'h0), 5'b00001), 5'b00000, 5'b00000);
        check("noport_strb", {635'h0, strb}, {635'h0, StrbNone});
        check("noport_port_held", {635'h0, m_axis_output_port_bit_array}, {635'h0, 5'b10000});

        // Reset mid-packet
        send_beat(d1, 1'b0, sume_b, 5'b00000, 5'b00000);
        check("midrst_b1_strb", {635'h0, strb}, {635'h0, StrbBeat});
        @(negedge clk);
        s_axis_valid = 1'b0;
        rstn = 1'b1;
        #1;
        check("midrst_outputs", all_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        // New packet dst=0x40 -> queue 3; must be judged as SOP
        m_c    = mk_meta(8'h40, 32'h1234_0006);
        sume_c = mk_sume(m_c, 5'b00011);
        send_beat(d2, 1'b0, sume_c, 5'b00000, 5'b00000);
        check("midrst_sop_strb", {635'h0, strb}, {635'h0, StrbBeat});
        check("midrst_sop_port", {635'h0, m_axis_output_port_bit_array}, {635'h0, 5'b01000});
        check("midrst_sop_meta", {512'h0, m_axis_sume_meta}, {512'h0, m_c});
        send_beat(d3, 1'b1, sume_c, 5'b00000, 5'b00000);
        check("midrst_last_strb", {635'h0, strb}, {635'h0, StrbLast});
        stall_cycle();
        check("final_idle_strb", {635'h0, strb}, {635'h0, StrbNone});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
